// File: rtl/icache_pkg.sv
// Shared constants and FSM state encoding for the instruction cache controller.
package icache_pkg;

  localparam int DATA_WIDTH         = 32;
  localparam int ADDR_WIDTH         = 32;
  localparam int ICACHE_INDEX_WIDTH = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MISS = 2'd1,
    RESP = 2'd2
  } state_e;

  // Upper address bits stored per line for a given index width (word-aligned addresses).
  function automatic int tag_width_for(input int index_width);
    return ADDR_WIDTH - 2 - index_width;
  endfunction

endpackage

// File: rtl/icache_array.sv
// Direct-mapped line storage: valid bits, tags and data words.
// Synchronous single-port write, combinational read by index.
module icache_array
  import icache_pkg::*;
#(
  parameter int INDEX_WIDTH = ICACHE_INDEX_WIDTH,
  parameter int TAG_WIDTH   = tag_width_for(ICACHE_INDEX_WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [INDEX_WIDTH-1:0] wr_index,
  input  logic [TAG_WIDTH-1:0]   wr_tag,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  input  logic [INDEX_WIDTH-1:0] rd_index,
  output logic                   rd_valid,
  output logic [TAG_WIDTH-1:0]   rd_tag,
  output logic [DATA_WIDTH-1:0]  rd_data
);

  localparam int LINES = 1 << INDEX_WIDTH;

  logic [LINES-1:0]      valid_q;
  logic [TAG_WIDTH-1:0]  tag_q  [LINES];
  logic [DATA_WIDTH-1:0] data_q [LINES];

  // NOTE: sequential state is written with non-blocking assignments only, so every
  // flop samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (we) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // NOTE: tag and data arrays are deliberately not reset; the valid bit alone
  // qualifies an entry, which keeps these arrays mappable onto plain RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped, one-word-per-line instruction cache between fetcher and memCtrl.
// Optional hit/miss counters are enabled with `define ICACHE_STAT_EN.
module icache_ctrl
  import icache_pkg::*;
#(
  parameter int INDEX_WIDTH = ICACHE_INDEX_WIDTH,
  parameter int TAG_WIDTH   = 32 - 2 - INDEX_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  in_fetcher_ce,
  input  logic [ADDR_WIDTH-1:0] in_fetcher_addr,
  output logic                  out_fetcher_ce,
  output logic [DATA_WIDTH-1:0] out_fetcher_instr,
  output logic                  out_fetcher_busy,
  output logic                  out_mem_ce,
  output logic [ADDR_WIDTH-1:0] out_mem_addr,
  input  logic                  in_mem_ce,
  input  logic [DATA_WIDTH-1:0] in_mem_data,
  input  logic                  in_rob_misbranch
`ifdef ICACHE_STAT_EN
  ,
  output logic [31:0]           out_hit_cnt,
  output logic [31:0]           out_miss_cnt
`endif
);

  state_e                state_q, state_nxt;
  logic                  fetcher_ce_nxt;
  logic [DATA_WIDTH-1:0] instr_nxt;
  logic                  mem_ce_nxt;
  logic [ADDR_WIDTH-1:0] mem_addr_nxt;
  logic                  fill_we;
  logic                  hit_acc, miss_acc;

  logic                  rd_valid;
  logic [TAG_WIDTH-1:0]  rd_tag;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  lookup_hit;

  // The refill always targets the line addressed by the latched miss address.
  icache_array #(
    .INDEX_WIDTH (INDEX_WIDTH),
    .TAG_WIDTH   (TAG_WIDTH)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .we       (fill_we && rdy),
    .wr_index (out_mem_addr[INDEX_WIDTH+1:2]),
    .wr_tag   (out_mem_addr[ADDR_WIDTH-1:INDEX_WIDTH+2]),
    .wr_data  (in_mem_data),
    .rd_index (in_fetcher_addr[INDEX_WIDTH+1:2]),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data)
  );

  assign lookup_hit       = rd_valid && (rd_tag == in_fetcher_addr[ADDR_WIDTH-1:INDEX_WIDTH+2]);
  assign out_fetcher_busy = (state_q != IDLE);

  // NOTE: every signal driven here gets a default first, so no path can leave one
  // unassigned and infer a latch.
  always_comb begin
    state_nxt      = state_q;
    fetcher_ce_nxt = 1'b0;
    instr_nxt      = out_fetcher_instr;
    mem_ce_nxt     = out_mem_ce;
    mem_addr_nxt   = out_mem_addr;
    fill_we        = 1'b0;
    hit_acc        = 1'b0;
    miss_acc       = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_fetcher_ce && !in_rob_misbranch) begin
          if (lookup_hit) begin
            hit_acc        = 1'b1;
            fetcher_ce_nxt = 1'b1;
            instr_nxt      = rd_data;
          end else begin
            miss_acc     = 1'b1;
            state_nxt    = MISS;
            mem_ce_nxt   = 1'b1;
            mem_addr_nxt = {in_fetcher_addr[ADDR_WIDTH-1:2], 2'b00};
          end
        end
      end
      MISS: begin
        if (in_mem_ce) begin
          fill_we        = 1'b1;
          mem_ce_nxt     = 1'b0;
          state_nxt      = RESP;
          fetcher_ce_nxt = 1'b1;
          instr_nxt      = in_mem_data;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // A misbranch kills any response or refill, but a returning fill is still written.
    if (in_rob_misbranch) begin
      state_nxt      = IDLE;
      mem_ce_nxt     = 1'b0;
      fetcher_ce_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q           <= IDLE;
      out_fetcher_ce    <= 1'b0;
      out_fetcher_instr <= '0;
      out_mem_ce        <= 1'b0;
      out_mem_addr      <= '0;
    end else if (rdy) begin
      state_q           <= state_nxt;
      out_fetcher_ce    <= fetcher_ce_nxt;
      out_fetcher_instr <= instr_nxt;
      out_mem_ce        <= mem_ce_nxt;
      out_mem_addr      <= mem_addr_nxt;
    end
  end

`ifdef ICACHE_STAT_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (rdy) begin
      if (hit_acc && (hit_cnt_q != '1))   hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss_acc && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign out_hit_cnt  = hit_cnt_q;
  assign out_miss_cnt = miss_cnt_q;
`else
  logic unused_stat;
  assign unused_stat = hit_acc ^ miss_acc;
`endif

  // Fetch addresses are word-aligned; the byte offset carries no information.
  logic unused_addr;
  assign unused_addr = ^in_fetcher_addr[1:0];

endmodule

// File: tb/tb_icache_ctrl.sv
// Randomized self-checking bench for icache_ctrl against a line-level cache model.
module tb_icache_ctrl;

  localparam int IW    = 6;
  localparam int TW    = 24;
  localparam int LINES = 1 << IW;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        in_fetcher_ce;
  logic [31:0] in_fetcher_addr;
  logic        out_fetcher_ce;
  logic [31:0] out_fetcher_instr;
  logic        out_fetcher_busy;
  logic        out_mem_ce;
  logic [31:0] out_mem_addr;
  logic        in_mem_ce;
  logic [31:0] in_mem_data;
  logic        in_rob_misbranch;
`ifdef ICACHE_STAT_EN
  logic [31:0] out_hit_cnt;
  logic [31:0] out_miss_cnt;
`endif

  icache_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .rdy               (rdy),
    .in_fetcher_ce     (in_fetcher_ce),
    .in_fetcher_addr   (in_fetcher_addr),
    .out_fetcher_ce    (out_fetcher_ce),
    .out_fetcher_instr (out_fetcher_instr),
    .out_fetcher_busy  (out_fetcher_busy),
    .out_mem_ce        (out_mem_ce),
    .out_mem_addr      (out_mem_addr),
    .in_mem_ce         (in_mem_ce),
    .in_mem_data       (in_mem_data),
    .in_rob_misbranch  (in_rob_misbranch)
`ifdef ICACHE_STAT_EN
    ,
    .out_hit_cnt       (out_hit_cnt),
    .out_miss_cnt      (out_miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference cache contents, indexed by line.
  bit          ref_valid [LINES];
  logic [TW-1:0] ref_tag [LINES];
  logic [31:0] ref_data  [LINES];
  int          exp_hits   = 0;
  int          exp_misses = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change and outputs are sampled at the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h13579BDF;
  endfunction

  function automatic int line_of(input logic [31:0] a);
    return int'(a[IW+1:2]);
  endfunction

  function automatic bit ref_hit(input logic [31:0] a);
    return ref_valid[line_of(a)] && (ref_tag[line_of(a)] == a[31:IW+2]);
  endfunction

  function automatic int pick_valid(input int start);
    for (int k = 0; k < LINES; k++) begin
      if (ref_valid[(start + k) % LINES]) return (start + k) % LINES;
    end
    return -1;
  endfunction

  // One complete lookup. mode 0: normal; 1: misbranch on refill cycle mb_at;
  // 2: misbranch together with the memCtrl done pulse.
  task automatic fetch(input logic [31:0] a, input logic [31:0] d, input int delay,
                       input int mode, input int mb_at);
    bit hit;
    int idx;
    hit = ref_hit(a);
    idx = line_of(a);
    in_fetcher_ce   = 1'b1;
    in_fetcher_addr = a;
    tick();
    in_fetcher_ce   = 1'b0;
    in_fetcher_addr = $urandom;
    if (hit) begin
      exp_hits++;
      check("hit_ce", out_fetcher_ce, 1);
      check("hit_instr", out_fetcher_instr, ref_data[idx]);
      check("hit_mem_ce", out_mem_ce, 0);
      check("hit_busy", out_fetcher_busy, 0);
      tick();
      check("hit_pulse", out_fetcher_ce, 0);
      return;
    end
    exp_misses++;
    for (int i = 1; i <= delay; i++) begin
      check("miss_mem_ce", out_mem_ce, 1);
      check("miss_addr", out_mem_addr, {a[31:2], 2'b00});
      check("miss_busy", out_fetcher_busy, 1);
      check("miss_no_resp", out_fetcher_ce, 0);
      if (mode == 1 && i == mb_at) begin
        in_rob_misbranch = 1'b1;
        tick();
        in_rob_misbranch = 1'b0;
        check("abort_mem_ce", out_mem_ce, 0);
        check("abort_ce", out_fetcher_ce, 0);
        check("abort_busy", out_fetcher_busy, 0);
        tick();
        check("abort_ce_late", out_fetcher_ce, 0);
        return;
      end
      if (i == delay) begin
        in_mem_ce   = 1'b1;
        in_mem_data = d;
        if (mode == 2) in_rob_misbranch = 1'b1;
      end
      tick();
      in_mem_ce        = 1'b0;
      in_rob_misbranch = 1'b0;
      in_mem_data      = $urandom;
    end
    ref_valid[idx] = 1'b1;
    ref_tag[idx]   = a[31:IW+2];
    ref_data[idx]  = d;
    if (mode == 2) begin
      check("mbfill_ce", out_fetcher_ce, 0);
      check("mbfill_mem_ce", out_mem_ce, 0);
      check("mbfill_busy", out_fetcher_busy, 0);
    end else begin
      check("resp_ce", out_fetcher_ce, 1);
      check("resp_instr", out_fetcher_instr, d);
      check("resp_mem_ce", out_mem_ce, 0);
      tick();
      check("resp_pulse", out_fetcher_ce, 0);
      check("resp_busy", out_fetcher_busy, 0);
    end
  endtask

  task automatic drop(input logic [31:0] a);
    in_fetcher_ce    = 1'b1;
    in_fetcher_addr  = a;
    in_rob_misbranch = 1'b1;
    tick();
    in_fetcher_ce    = 1'b0;
    in_rob_misbranch = 1'b0;
    check("drop_ce", out_fetcher_ce, 0);
    check("drop_mem_ce", out_mem_ce, 0);
    check("drop_busy", out_fetcher_busy, 0);
  endtask

  task automatic hit_burst(input int n);
    int idx;
    for (int i = 0; i < n; i++) begin
      idx = pick_valid(int'($urandom_range(0, LINES - 1)));
      if (idx < 0) break;
      in_fetcher_ce   = 1'b1;
      in_fetcher_addr = {ref_tag[idx], 6'(idx), 2'b00};
      exp_hits++;
      tick();
      check("burst_ce", out_fetcher_ce, 1);
      check("burst_instr", out_fetcher_instr, ref_data[idx]);
    end
    in_fetcher_ce = 1'b0;
    tick();
    check("burst_end", out_fetcher_ce, 0);
  endtask

  task automatic clear_model();
    for (int i = 0; i < LINES; i++) ref_valid[i] = 1'b0;
    exp_hits   = 0;
    exp_misses = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int r, dly, mode;
    rst = 1'b0; rdy = 1'b1;
    in_fetcher_ce = 1'b0; in_fetcher_addr = '0;
    in_mem_ce = 1'b0; in_mem_data = '0; in_rob_misbranch = 1'b0;
    clear_model();
    @(negedge clk);
    @(negedge clk);
    check("rst_fetcher_ce", out_fetcher_ce, 0);
    check("rst_instr", out_fetcher_instr, 0);
    check("rst_mem_ce", out_mem_ce, 0);
    check("rst_mem_addr", out_mem_addr, 0);
    check("rst_busy", out_fetcher_busy, 0);
    rst = 1'b1;
    tick();

    // Directed scenarios.
    fetch(32'h0000_0000, 32'h0000_0513, 4, 0, 0);
    fetch(32'h0000_0000, 32'h0, 1, 0, 0);
    fetch(32'h0000_0100, 32'h1111_1111, 3, 0, 0);
    fetch(32'h0000_0000, 32'h0000_0513, 2, 0, 0);
    fetch(32'h0000_0040, 32'hAAAA_AAAA, 4, 1, 2);
    fetch(32'h0000_0040, 32'hBBBB_BBBB, 1, 0, 0);
    fetch(32'h0000_0004, 32'hDEAD_BEEF, 3, 2, 0);
    fetch(32'h0000_0004, 32'h0, 1, 0, 0);
    check("dir_fill_ref", ref_data[1], 32'hDEAD_BEEF);
    fetch(32'hFFFF_FF04, 32'h7777_0001, 2, 0, 0);
    drop(32'h0000_0000);
    hit_burst(4);

    // Freeze during MISS, then asynchronous reset mid-refill.
    in_fetcher_ce = 1'b1; in_fetcher_addr = 32'h0000_0008;
    tick();
    in_fetcher_ce = 1'b0;
    check("frz_mem_ce0", out_mem_ce, 1);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_mem_ce = 1'b1; in_mem_data = 32'h5555_AAAA;
      tick();
      check("frz_mem_ce", out_mem_ce, 1);
      check("frz_mem_addr", out_mem_addr, 32'h0000_0008);
      check("frz_busy", out_fetcher_busy, 1);
      check("frz_ce", out_fetcher_ce, 0);
    end
    in_mem_ce = 1'b0;
    rdy = 1'b1;
    tick();
    check("frz_resume_mem_ce", out_mem_ce, 1);
    #2 rst = 1'b0;
    #1;
    check("arst_mem_ce", out_mem_ce, 0);
    check("arst_busy", out_fetcher_busy, 0);
    check("arst_mem_addr", out_mem_addr, 0);
    clear_model();
    @(negedge clk);
    rst = 1'b1;
    tick();
    fetch(32'h0000_0000, 32'h0000_0513, 2, 0, 0);
    fetch(32'h0000_0008, 32'h0808_0808, 1, 0, 0);

    // Randomized traffic over a small address pool to force hits and conflicts.
    for (int n = 0; n < 120; n++) begin
      r = int'($urandom_range(0, 9));
      case ($urandom_range(0, 2))
        0:       a = 32'h0000_0000;
        1:       a = 32'h0000_0100;
        default: a = 32'h8000_0000;
      endcase
      a[4:2] = 3'($urandom_range(0, 7));
      dly  = int'($urandom_range(1, 5));
      mode = (r == 2) ? 1 : (r == 3) ? 2 : 0;
      if (r == 0)      drop(a);
      else if (r == 1) hit_burst(int'($urandom_range(2, 5)));
      else             fetch(a, mem_word(a), dly, mode, int'($urandom_range(1, dly)));
    end

`ifdef ICACHE_STAT_EN
    check("stat_hits", out_hit_cnt, exp_hits);
    check("stat_misses", out_miss_cnt, exp_misses);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
